pipeline_stall_controller: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32I core.
- Combines three inputs into per-stage write-enables and flushes:
  - the load-use stall from the hazard detector,
  - branch redirects resolved in EX,
  - multi-cycle instruction- and data-memory handshakes.
- Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves simultaneous events by stage age: the oldest stage wins.

---
 rtl/pipeline_stall_controller_pkg.sv | 37 +++
 rtl/pipeline_stall_controller_if.sv | 31 +++
 rtl/pipeline_stall_controller_mem_wait_timer.sv | 25 ++
 rtl/pipeline_stall_controller.sv | 125 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, the per-stage
// control bundle and its canned values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        ERROR    = 2'd3
    } state_e;

    // Field order fixes the bit layout of every constant below (pc_we is MSB).
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_we;
        logic memwb_we;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FREEZE   = 6'b000000;
    localparam stage_ctrl_t CTRL_NORMAL   = 6'b110011;
    localparam stage_ctrl_t CTRL_RESET    = 6'b001100;
    localparam stage_ctrl_t CTRL_BRANCH   = 6'b111111;
    localparam stage_ctrl_t CTRL_LOAD_USE = 6'b000111;
    localparam stage_ctrl_t CTRL_REDIRECT = 6'b011011;

    // Branch flush beats the load-use bubble: the stalled instruction is in ID
    // and gets flushed anyway.
    function automatic stage_ctrl_t run_rules(input logic branch, input logic load_use);
        if (branch)        return CTRL_BRANCH;
        else if (load_use) return CTRL_LOAD_USE;
        else               return CTRL_NORMAL;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard / memory event inputs and per-stage controls of the pipeline sequencer.
// master = core side (drives events), slave = sequencer.
interface pipeline_stall_controller_if;
    logic        load_use_stall;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ack;
    logic        imem_ready;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_we;
    logic        memwb_we;
    logic        mem_timeout_err;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
    logic [31:0] perf_mem_wait;

    modport master (
        output load_use_stall, branch_taken, dmem_req, dmem_ack, imem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we,
        input  mem_timeout_err, perf_stall_cycles, perf_flushes, perf_mem_wait
    );

    modport slave (
        input  load_use_stall, branch_taken, dmem_req, dmem_ack, imem_ready,
        output pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we,
        output mem_timeout_err, perf_stall_cycles, perf_flushes, perf_mem_wait
    );
endinterface

// File: rtl/pipeline_stall_controller_mem_wait_timer.sv
// Data-memory wait counter. clr and inc together load 1 (first wait cycle).
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_hit
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q;
        if (inc_i) cnt_d = cnt_d + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign timeout_hit = (cnt_q == CNT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage core. Oldest stage wins.
// Define PIPE_PERF_CNT_EN to build the performance counters; otherwise they read 0.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    pipeline_stall_controller_if.slave bus
);
    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic        tmr_clr, tmr_inc, tmr_hit;
    logic        dmiss;
    stage_ctrl_t ctrl, ctrl_out;

    assign dmiss = bus.dmem_req && !bus.dmem_ack;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (tmr_clr),
        .inc_i       (tmr_inc),
        .timeout_hit (tmr_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ctrl    = CTRL_FREEZE;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmiss) begin
                    state_d = MEM_WAIT;
                    tmr_clr = 1'b1;
                    tmr_inc = 1'b1;
                end else begin
                    ctrl    = run_rules(bus.branch_taken, bus.load_use_stall);
                    state_d = (bus.branch_taken && !bus.imem_ready) ? REDIRECT : RUN;
                end
            end
            MEM_WAIT: begin
                if (!bus.dmem_ack) begin
                    if (tmr_hit) state_d = ERROR;
                    else         tmr_inc = 1'b1;
                end else begin
                    // EX was frozen, so a branch seen here is still the live one.
                    ctrl    = run_rules(bus.branch_taken, bus.load_use_stall);
                    tmr_clr = 1'b1;
                    pend_d  = 1'b0;
                    state_d = (pend_q || (bus.branch_taken && !bus.imem_ready)) ? REDIRECT : RUN;
                end
            end
            REDIRECT: begin
                pend_d = 1'b0;
                if (dmiss) begin
                    pend_d  = 1'b1;
                    state_d = MEM_WAIT;
                    tmr_clr = 1'b1;
                    tmr_inc = 1'b1;
                end else if (bus.imem_ready) begin
                    ctrl    = CTRL_NORMAL;
                    state_d = RUN;
                end else begin
                    ctrl = CTRL_REDIRECT;
                end
            end
            ERROR: ;
            default: state_d = RUN;
        endcase
    end

    assign ctrl_out = reset ? CTRL_RESET : ctrl;

    assign bus.pc_we           = ctrl_out.pc_we;
    assign bus.ifid_we         = ctrl_out.ifid_we;
    assign bus.ifid_flush      = ctrl_out.ifid_flush;
    assign bus.idex_flush      = ctrl_out.idex_flush;
    assign bus.exmem_we        = ctrl_out.exmem_we;
    assign bus.memwb_we        = ctrl_out.memwb_we;
    assign bus.mem_timeout_err = !reset && (state_q == ERROR);

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, flush_q, mwait_q;
    logic        flush_evt;

    // A branch flush is taken in RUN without a miss, or on the ack cycle of MEM_WAIT.
    assign flush_evt = bus.branch_taken &&
                       (((state_q == RUN) && !dmiss) || ((state_q == MEM_WAIT) && bus.dmem_ack));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            mwait_q <= '0;
        end else begin
            if (!ctrl_out.pc_we)      stall_q <= stall_q + 32'd1;
            if (flush_evt)            flush_q <= flush_q + 32'd1;
            if (state_q == MEM_WAIT)  mwait_q <= mwait_q + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = stall_q;
    assign bus.perf_flushes      = flush_q;
    assign bus.perf_mem_wait     = mwait_q;
`else
    assign bus.perf_stall_cycles = '0;
    assign bus.perf_flushes      = '0;
    assign bus.perf_mem_wait     = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; control bundle is compared as
// {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we}.
module tb_pipeline_stall_controller;
    localparam int TMO = 8;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] NRM = 6'b110011;
    localparam logic [5:0] RST = 6'b001100;
    localparam logic [5:0] BRF = 6'b111111;
    localparam logic [5:0] LUB = 6'b000111;
    localparam logic [5:0] RDR = 6'b011011;
`ifdef PIPE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [5:0]  ctl;
    logic [95:0] perf, perf_exp;

    pipeline_stall_controller_if bus();

    pipeline_stall_controller #(.MEM_TIMEOUT(TMO), .CNT_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign ctl  = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_flush, bus.exmem_we, bus.memwb_we};
    assign perf = {bus.perf_stall_cycles, bus.perf_flushes, bus.perf_mem_wait};

    task automatic set_in(input logic lus, input logic br, input logic req, input logic ack, input logic imem);
        bus.load_use_stall = lus;
        bus.branch_taken   = br;
        bus.dmem_req       = req;
        bus.dmem_ack       = ack;
        bus.imem_ready     = imem;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ctl !== RST) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, RST); end
        checks++; if (bus.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.mem_timeout_err); end
        checks++; if (perf !== 96'd0) begin errors++; $display("FAIL reset_perf got=%h exp=0", perf); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL reset_first_run got=%b exp=%b", ctl, NRM); end
        tick();
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (ctl !== LUB) begin errors++; $display("FAIL lu_bubble got=%b exp=%b", ctl, LUB); end
        tick();
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL lu_after got=%b exp=%b", ctl, NRM); end
        tick();
    endtask

    task automatic test_branch_redirect();
        set_in(1, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if (ctl !== BRF) begin errors++; $display("FAIL br_flush got=%b exp=%b", ctl, BRF); end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0);
            @(negedge clk);
            checks++; if (ctl !== RDR) begin errors++; $display("FAIL br_redirect%0d got=%b exp=%b", i, ctl, RDR); end
            tick();
        end
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL br_fetch_ok got=%b exp=%b", ctl, NRM); end
        tick();
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL br_back_run got=%b exp=%b", ctl, NRM); end
        tick();
    endtask

    task automatic test_mem_wait_branch();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 1, 0, 1);
            @(negedge clk);
            checks++; if (ctl !== FRZ) begin errors++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, ctl, FRZ); end
            tick();
        end
        set_in(0, 1, 1, 1, 1);
        @(negedge clk);
        checks++; if (ctl !== BRF) begin errors++; $display("FAIL mw_ack_flush got=%b exp=%b", ctl, BRF); end
        tick();
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL mw_after got=%b exp=%b", ctl, NRM); end
        tick();
    endtask

    task automatic test_zero_wait();
        set_in(1, 0, 1, 1, 1);
        @(negedge clk);
        checks++; if (ctl !== LUB) begin errors++; $display("FAIL zw_bubble got=%b exp=%b", ctl, LUB); end
        tick();
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL zw_after got=%b exp=%b", ctl, NRM); end
        tick();
    endtask

    task automatic test_redirect_mem();
        set_in(0, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if (ctl !== BRF) begin errors++; $display("FAIL rm_branch got=%b exp=%b", ctl, BRF); end
        tick();
        set_in(0, 0, 1, 0, 0);
        @(negedge clk);
        checks++; if (ctl !== FRZ) begin errors++; $display("FAIL rm_miss_in_redirect got=%b exp=%b", ctl, FRZ); end
        tick();
        @(negedge clk);
        checks++; if (ctl !== FRZ) begin errors++; $display("FAIL rm_wait got=%b exp=%b", ctl, FRZ); end
        tick();
        set_in(0, 0, 1, 1, 0);
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL rm_ack got=%b exp=%b", ctl, NRM); end
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (ctl !== RDR) begin errors++; $display("FAIL rm_pending_redirect got=%b exp=%b", ctl, RDR); end
        tick();
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL rm_fetch_ok got=%b exp=%b", ctl, NRM); end
        tick();
        @(negedge clk);
        checks++; if (ctl !== NRM) begin errors++; $display("FAIL rm_back_run got=%b exp=%b", ctl, NRM); end
        perf_exp = (PERF != 0) ? {32'd12, 32'd3, 32'd6} : 96'd0;
        checks++; if (perf !== perf_exp) begin errors++; $display("FAIL perf_mid got=%h exp=%h", perf, perf_exp); end
        tick();
    endtask

    task automatic test_timeout();
        set_in(0, 0, 1, 0, 1);
        @(negedge clk);
        checks++; if (ctl !== FRZ) begin errors++; $display("FAIL to_first got=%b exp=%b", ctl, FRZ); end
        tick();
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            checks++; if ({ctl, bus.mem_timeout_err} !== {FRZ, 1'b0}) begin
                errors++; $display("FAIL to_wait%0d got=%b/%b exp=%b/0", i, ctl, bus.mem_timeout_err, FRZ);
            end
            tick();
        end
        @(negedge clk);
        checks++; if ({ctl, bus.mem_timeout_err} !== {FRZ, 1'b1}) begin
            errors++; $display("FAIL to_error got=%b/%b exp=%b/1", ctl, bus.mem_timeout_err, FRZ);
        end
        perf_exp = (PERF != 0) ? {32'd21, 32'd3, 32'd14} : 96'd0;
        checks++; if (perf !== perf_exp) begin errors++; $display("FAIL perf_error got=%h exp=%h", perf, perf_exp); end
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 0, 0, 1);
            @(negedge clk);
            checks++; if ({ctl, bus.mem_timeout_err} !== {FRZ, 1'b1}) begin
                errors++; $display("FAIL to_sticky%0d got=%b/%b exp=%b/1", i, ctl, bus.mem_timeout_err, FRZ);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 1);
        reset = 1'b1;
        #2;
        checks++; if ({ctl, bus.mem_timeout_err} !== {RST, 1'b0}) begin
            errors++; $display("FAIL to_reset got=%b/%b exp=%b/0", ctl, bus.mem_timeout_err, RST);
        end
        checks++; if (perf !== 96'd0) begin errors++; $display("FAIL to_reset_perf got=%h exp=0", perf); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({ctl, bus.mem_timeout_err} !== {NRM, 1'b0}) begin
            errors++; $display("FAIL to_after_reset got=%b/%b exp=%b/0", ctl, bus.mem_timeout_err, NRM);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_redirect();
        test_mem_wait_branch();
        test_zero_wait();
        test_redirect_mem();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
